// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the synchronous status FIFO.
// Optional almost-full/almost-empty flags are enabled with FIFO_ALMOST_FLAGS_EN.
package fifo_pkg;

    // Default geometry used by the FIFO, its interface and the bench
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 16;

    // Distance from the ends at which the almost flags assert
    localparam int FIFO_ALMOST_MARGIN = 2;

    // Data word at the default width
    typedef logic [FIFO_DATA_WIDTH-1:0] fifo_data_t;

    // Occupancy classification, handy for monitors and debug displays
    typedef enum logic [1:0] {
        FIFO_LVL_EMPTY   = 2'd0,
        FIFO_LVL_PARTIAL = 2'd1,
        FIFO_LVL_FULL    = 2'd2
    } fifo_level_e;

    // Classify an occupancy value against a depth
    function automatic fifo_level_e fifo_level(input int level, input int depth);
        if (level == 0) begin
            return FIFO_LVL_EMPTY;
        end else if (level >= depth) begin
            return FIFO_LVL_FULL;
        end else begin
            return FIFO_LVL_PARTIAL;
        end
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_if.sv
// fifo_if: bundles every port of sync_fifo_status; clk is the interface port.
// The almost flags exist only when FIFO_ALMOST_FLAGS_EN is defined.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input logic clk
);

    logic                  rst;
    logic                  write_enable;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
    logic                  overrun;
    logic                  underrun;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic                  almost_full;
    logic                  almost_empty;
`endif

    // View from the FIFO itself
    modport dut (
        input  clk, rst, write_enable, read_enable, data_in,
        output data_out, full, empty, overflow, underflow, overrun, underrun
`ifdef FIFO_ALMOST_FLAGS_EN
        , output almost_full, almost_empty
`endif
    );

    // View from a producer/consumer pair driving the FIFO
    modport user (
        input  clk, data_out, full, empty, overflow, underflow, overrun, underrun,
        output rst, write_enable, read_enable, data_in
`ifdef FIFO_ALMOST_FLAGS_EN
        , input almost_full, almost_empty
`endif
    );

endinterface : fifo_if

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage with one synchronous write port and
// one synchronous (registered) read port. Contents and read register are not reset.
module fifo_mem #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Write port: store the incoming word at the write address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word; a same-edge write to the same
    // address is seen by the next read, so the old (oldest) word is returned
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule : fifo_mem

// File: rtl/sync_fifo_status.sv
// sync_fifo_status: single-clock FIFO with registered read data, full/empty
// level flags, one-cycle overflow/underflow pulses and sticky overrun/underrun.
// Define FIFO_ALMOST_FLAGS_EN to add the almost_full/almost_empty outputs.
module sync_fifo_status
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter  int DEPTH      = FIFO_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  overrun,
    output logic                  underrun
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0]  COUNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  COUNT_ONE  = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    // Architectural state
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic [CNT_WIDTH-1:0]  count_next;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  overrun_reg;
    logic                  underrun_reg;

    // Set once a read has been accepted since reset; until then the read
    // register inside the memory holds stale data and data_out must read 0
    logic                  rd_valid_reg;

    // Handshake decisions for the current cycle
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_reject;
    logic                  rd_reject;
    logic [DATA_WIDTH-1:0] rd_data;

    // Level flags straight from the registered count
    assign full  = (count_reg == COUNT_FULL);
    assign empty = (count_reg == '0);

    // A read needs data; a write needs room, or a same-cycle read freeing a slot
    assign rd_acc    = read_enable & ~empty;
    assign wr_acc    = write_enable & (~full | rd_acc);
    assign wr_reject = write_enable & ~wr_acc;
    assign rd_reject = read_enable & ~rd_acc;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    // Next occupancy: simultaneous accepted read and write cancel out
    always_comb begin
        count_next = count_reg;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Pointers advance only on accepted operations and wrap modulo DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Occupancy register; reset discards everything stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Error pulses last one cycle per rejected request; sticky flags latch them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            overflow_reg  <= wr_reject;
            underflow_reg <= rd_reject;
            if (wr_reject) begin
                overrun_reg <= 1'b1;
            end
            if (rd_reject) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    // Track whether the memory read register holds a word read since reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
        end else if (rd_acc) begin
            rd_valid_reg <= 1'b1;
        end
    end

    // Read data holds the last accepted read; zero before any read after reset
    assign data_out  = rd_valid_reg ? rd_data : '0;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign overrun   = overrun_reg;
    assign underrun  = underrun_reg;

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [CNT_WIDTH-1:0] ALMOST_FULL_LEVEL  = CNT_WIDTH'(DEPTH - FIFO_ALMOST_MARGIN);
    localparam logic [CNT_WIDTH-1:0] ALMOST_EMPTY_LEVEL = CNT_WIDTH'(FIFO_ALMOST_MARGIN);

    // Early-warning flags, also combinational from the registered count
    assign almost_full  = (count_reg >= ALMOST_FULL_LEVEL);
    assign almost_empty = (count_reg <= ALMOST_EMPTY_LEVEL);
`endif

endmodule : sync_fifo_status

// File: tb/tb_sync_fifo_status.sv
// tb_sync_fifo_status: directed scenarios plus randomized traffic against a
// queue-based reference model of the FIFO. Honors FIFO_ALMOST_FLAGS_EN.
module tb_sync_fifo_status;
    import fifo_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_enable = 1'b0;
    logic       read_enable  = 1'b0;
    fifo_data_t data_in      = '0;
    fifo_data_t data_out;
    logic       full, empty, overflow, underflow, overrun, underrun;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic       almost_full, almost_empty;
`endif

    sync_fifo_status #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .overrun      (overrun),
        .underrun     (underrun)
`ifdef FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue plus expected registered outputs
    fifo_data_t model_q[$];
    fifo_data_t exp_dout;
    bit         exp_ovf, exp_udf, exp_ovr, exp_udr;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h (txn %0d, t=%0t)",
                     tag, observed, expected, txn, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        int lvl;
        lvl = model_q.size();
        check_value({tag, ".data_out"},  32'(data_out),  32'(exp_dout));
        check_value({tag, ".full"},      32'(full),      32'(lvl == DEPTH));
        check_value({tag, ".empty"},     32'(empty),     32'(lvl == 0));
        check_value({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        check_value({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
        check_value({tag, ".overrun"},   32'(overrun),   32'(exp_ovr));
        check_value({tag, ".underrun"},  32'(underrun),  32'(exp_udr));
`ifdef FIFO_ALMOST_FLAGS_EN
        check_value({tag, ".almost_full"},  32'(almost_full),  32'(lvl >= DEPTH - 2));
        check_value({tag, ".almost_empty"}, 32'(almost_empty), 32'(lvl <= 2));
`endif
    endtask

    // One clock cycle of traffic; model applies the FIFO rules to pre-edge state
    task automatic step(input string tag, input bit we, input bit re, input fifo_data_t din);
        bit rd_acc, wr_acc;
        write_enable = we;
        read_enable  = re;
        data_in      = din;
        @(posedge clk);
        rd_acc = re && (model_q.size() > 0);
        wr_acc = we && ((model_q.size() < DEPTH) || rd_acc);
        if (rd_acc) exp_dout = model_q.pop_front();
        if (wr_acc) model_q.push_back(din);
        exp_ovf = we && !wr_acc;
        exp_udf = re && !rd_acc;
        if (exp_ovf) exp_ovr = 1'b1;
        if (exp_udf) exp_udr = 1'b1;
        #1;
        txn++;
        $display("txn %0d %s we=%0b re=%0b din=%02h dout=%02h lvl=%0d",
                 txn, tag, we, re, din, data_out, model_q.size());
        compare_all(tag);
    endtask

    // Asynchronous reset away from the clock edge; checks take effect at once
    task automatic async_reset(input string tag);
        write_enable = 1'b0;
        read_enable  = 1'b0;
        rst = 1'b1;
        #1;
        model_q.delete();
        exp_dout = '0;
        exp_ovf = 1'b0; exp_udf = 1'b0; exp_ovr = 1'b0; exp_udr = 1'b0;
        txn++;
        $display("txn %0d %s reset", txn, tag);
        compare_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        fifo_data_t basic_data[3];
        basic_data[0] = 8'hA1; basic_data[1] = 8'hB2; basic_data[2] = 8'hC3;

        exp_dout = '0;
        #2;
        async_reset("reset");

        // Basic ordering and one-cycle read latency
        for (int i = 0; i < 3; i++) step("basic_wr", 1'b1, 1'b0, basic_data[i]);
        for (int i = 0; i < 3; i++) begin
            step("basic_rd", 1'b0, 1'b1, 8'h00);
            check_value("basic.order", 32'(data_out), 32'(basic_data[i]));
        end

        // Fill to full, then drain in order
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, fifo_data_t'(i));
        check_value("fill.full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, 1'b1, 8'h00);
            check_value("drain.order", 32'(data_out), 32'(i));
            if (i == 0) check_value("drain.full_drop", 32'(full), 32'd0);
        end
        check_value("drain.empty", 32'(empty), 32'd1);

        // Overflow pulse, sticky overrun, rejected word never stored
        for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 1'b0, fifo_data_t'(i + 16));
        step("ovf_wr", 1'b1, 1'b0, 8'hFF);
        check_value("ovf.pulse", 32'(overflow), 32'd1);
        step("ovf_idle", 1'b0, 1'b0, 8'h00);
        check_value("ovf.one_cycle", 32'(overflow), 32'd0);
        check_value("ovf.sticky", 32'(overrun), 32'd1);
        for (int i = 0; i < DEPTH; i++) step("ovf_drain", 1'b0, 1'b1, 8'h00);

        // Underflow on empty after reset; data_out stays zero
        async_reset("reset2");
        step("udf_rd", 1'b0, 1'b1, 8'h00);
        check_value("udf.pulse", 32'(underflow), 32'd1);
        check_value("udf.dout", 32'(data_out), 32'd0);
        step("udf_idle", 1'b0, 1'b0, 8'h00);
        check_value("udf.sticky", 32'(underrun), 32'd1);

        // Simultaneous read+write while empty: write wins, read rejected
        step("empty_rw", 1'b1, 1'b1, 8'h33);
        step("empty_rd", 1'b0, 1'b1, 8'h00);

        // Simultaneous read+write while full: both accepted, 0x5A read last
        for (int i = 0; i < DEPTH; i++) step("fill3", 1'b1, 1'b0, fifo_data_t'(i + 64));
        step("full_rw", 1'b1, 1'b1, 8'h5A);
        check_value("full_rw.full", 32'(full), 32'd1);
        check_value("full_rw.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) step("full_drain", 1'b0, 1'b1, 8'h00);
        check_value("full_rw.last", 32'(data_out), 32'h5A);

        // Reset mid-stream discards contents immediately
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, fifo_data_t'(i + 128));
        step("pre_rst_ovf", 1'b0, 1'b1, 8'h00);
        async_reset("mid_reset");

        // Randomized traffic with shifting read/write bias and rare resets
        for (int blk = 0; blk < 20; blk++) begin
            int wp, rp;
            wp = int'($urandom_range(10, 90));
            rp = int'($urandom_range(10, 90));
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 399) == 0) begin
                    async_reset("rand_rst");
                end else begin
                    step("rand",
                         $urandom_range(0, 99) < wp,
                         $urandom_range(0, 99) < rp,
                         fifo_data_t'($urandom));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_fifo_status
